// File: rtl/vga_pattern_gen.sv
// VGA timing generator with solid / bars / checker / gradient test patterns.
// Optional horizontal scrolling via `define VGA_PATTERN_SCROLL_EN.
module vga_pattern_gen #(
    parameter int CW       = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic [1:0]    mode,
    input  logic [3*CW-1:0] color,
    output logic [3*CW-1:0] rgb,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int XW = (HW > CW + 3) ? HW : CW + 3;
    // y only feeds the checker bit 5 and the gradient slice
    localparam int YW = (CW + 3 > 6) ? CW + 3 : 6;

    logic [HW-1:0]   r_h;
    logic [VW-1:0]   r_v;
    logic [1:0]      r_mode;
    logic [3*CW-1:0] r_color;
    logic            w_h_last, w_v_last, w_origin, w_act;
    logic [XW-1:0]   w_xeff;

    assign w_h_last = (r_h == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v == VW'(V_TOTAL - 1));
    assign w_origin = (r_h == '0) && (r_v == '0);
    assign w_act    = (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (pix_en) begin
            r_h <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last)
                r_v <= w_v_last ? '0 : r_v + 1'b1;
        end
    end

    // Pattern controls latch at the origin so a frame is never mixed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode  <= '0;
            r_color <= '0;
        end else if (pix_en && w_origin) begin
            r_mode  <= mode;
            r_color <= color;
        end
    end

`ifdef VGA_PATTERN_SCROLL_EN
    logic [XW-1:0] r_off;
    logic [XW:0]   w_xsum;

    // Bumped on the last scan position so the whole next frame sees one offset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_off <= '0;
        else if (pix_en && w_h_last && w_v_last)
            r_off <= (r_off == XW'(H_ACTIVE - 1)) ? '0 : r_off + 1'b1;
    end

    assign w_xsum = {1'b0, XW'(r_h)} + {1'b0, r_off};
    assign w_xeff = (w_xsum >= (XW+1)'(H_ACTIVE)) ? XW'(w_xsum - (XW+1)'(H_ACTIVE))
                                                  : XW'(w_xsum);
`else
    assign w_xeff = XW'(r_h);
`endif

    logic          r1_act, r1_hs, r1_vs, r1_first;
    logic [XW-1:0] r1_x;
    logic [YW-1:0] r1_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_act   <= 1'b0;
            r1_hs    <= ~SYNC_POL;
            r1_vs    <= ~SYNC_POL;
            r1_first <= 1'b0;
            r1_x     <= '0;
            r1_y     <= '0;
        end else if (pix_en) begin
            r1_act   <= w_act;
            r1_hs    <= (r_h >= HW'(H_ACTIVE + H_FP) && r_h < HW'(H_ACTIVE + H_FP + H_SYNC))
                        ? SYNC_POL : ~SYNC_POL;
            r1_vs    <= (r_v >= VW'(V_ACTIVE + V_FP) && r_v < VW'(V_ACTIVE + V_FP + V_SYNC))
                        ? SYNC_POL : ~SYNC_POL;
            r1_first <= w_origin;
            r1_x     <= w_xeff;
            r1_y     <= YW'(r_v);
        end
    end

    logic [2:0]      w_bar;
    logic [3*CW-1:0] w_pix;

    always_comb begin
        w_bar = 3'((32'(r1_x) << 3) / 32'(H_ACTIVE));
        w_pix = '0;
        case (r_mode)
            2'd0: w_pix = r_color;
            2'd1: w_pix = {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}};
            2'd2: w_pix = (r1_x[5] ^ r1_y[5]) ? '0 : r_color;
            default: w_pix = {r1_x[CW+2:3], r1_y[CW+2:3], r1_x[CW+2:3] ^ r1_y[CW+2:3]};
        endcase
        if (!r1_act)
            w_pix = '0;
    end

    // frame_start drops on idle clocks so it never stretches past one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb         <= '0;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            rgb         <= w_pix;
            h_sync      <= r1_hs;
            v_sync      <= r1_vs;
            video_on    <= r1_act;
            frame_start <= r1_first;
        end else begin
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen on a shrunken raster; the reference
// derives every presented pixel from the count of enabled ticks since reset.
module tb_vga_pattern_gen;
    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [1:0]  mode;
    logic [11:0] color;
    logic [11:0] rgb;
    logic        h_sync, v_sync, video_on, frame_start;

    vga_pattern_gen #(
        .CW(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode), .color(color),
        .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int k;
    logic last_en;
    logic [1:0]  fmode [64];
    logic [11:0] fcolor[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s tick=%0d got=%h exp=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [11:0] pat(input int f, input int h, input int v);
        int xe, bi;
        logic [2:0] b3;
        logic [11:0] c;
`ifdef VGA_PATTERN_SCROLL_EN
        xe = (h + (f % HA)) % HA;
`else
        xe = h;
`endif
        c = fcolor[f];
        case (fmode[f])
            2'd0: return c;
            2'd1: begin
                bi = xe * 8 / HA;
                b3 = 3'(bi);
                return {{4{b3[2]}}, {4{b3[1]}}, {4{b3[0]}}};
            end
            2'd2: return ((((xe >> 5) ^ (v >> 5)) & 1) != 0) ? 12'h000 : c;
            default: return {4'(xe >> 3), 4'(v >> 3), 4'((xe ^ v) >> 3)};
        endcase
    endfunction

    task automatic check_all();
        logic [11:0] er;
        logic ehs, evs, eon, efs;
        int p, f, h, v;
        if (k < 2) begin
            er = 12'h000; ehs = 1'b1; evs = 1'b1; eon = 1'b0; efs = 1'b0;
        end else begin
            p = k - 2;
            f = p / FT;
            h = p % HT;
            v = (p / HT) % VT;
            eon = (h < HA) && (v < VA);
            ehs = (h >= HA + HFP && h < HA + HFP + HS) ? 1'b0 : 1'b1;
            evs = (v >= VA + VFP && v < VA + VFP + VS) ? 1'b0 : 1'b1;
            efs = last_en && (p % FT == 0);
            er  = eon ? pat(f, h, v) : 12'h000;
        end
        chk("rgb", 32'(rgb), 32'(er));
        chk("h_sync", 32'(h_sync), 32'(ehs));
        chk("v_sync", 32'(v_sync), 32'(evs));
        chk("video_on", 32'(video_on), 32'(eon));
        chk("frame_start", 32'(frame_start), 32'(efs));
    endtask

    // Drive one cycle's inputs, advance the reference, then check at negedge.
    task automatic step(input logic en);
        pix_en = en;
        if ($urandom_range(0, 1999) == 0) mode = 2'($urandom);
        if ($urandom_range(0, 999) == 0) color = 12'($urandom);
        if (en) begin
            k++;
            if ((k - 1) % FT == 0 && (k - 1) / FT < 64) begin
                fmode[(k - 1) / FT]  = mode;
                fcolor[(k - 1) / FT] = color;
            end
            if (k % FT == FT / 2) begin
                mode  = mode + 2'd1;
                color = 12'($urandom);
            end
        end
        last_en = en;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; mode = 2'd0; color = 12'hF80;
        k = 0; last_en = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        reset = 1'b0;

        for (int i = 0; i < 36000; i++)
            step($urandom_range(0, 3) != 0);

        // asynchronous reset landing between clock edges
        #2 reset = 1'b1;
        #1;
        k = 0; last_en = 1'b0;
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b0;
        mode = 2'd2;

        for (int i = 0; i < 16000; i++)
            step(i[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter CW, default 4, bits per colour channel (rgb is 3*CW, ordered {R,G,B}).
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, giving the timing in pixels/lines.
REQ-003 SHALL have parameter SYNC_POL, default 0, the sync level while the sync pulse is active.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pix_en  input  1  pixel tick; all counters and pipeline stages advance only on clk edges with pix_en=1.
REQ-007 mode  input  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient.
REQ-008 color  input  3*CW  solid/checker foreground colour.
REQ-009 rgb  output  3*CW  registered pixel colour.
REQ-010 h_sync, v_sync  output  1 each  registered sync outputs.
REQ-011 video_on  output  1  registered; high while the presented pixel is active.
REQ-012 frame_start  output  1  one-clk pulse when the output register loads pixel (0,0).

Function
REQ-013 SHALL keep h_cnt in 0..H_TOTAL-1 (H_TOTAL = sum of H_* params), wrapping to 0; v_cnt SHALL increment on h_cnt wrap and wrap at V_TOTAL-1 to 0.
REQ-014 Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; x=h_cnt, y=v_cnt.
REQ-015 h_sync SHALL be SYNC_POL for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~SYNC_POL; v_sync likewise on v_cnt with V_* params.
REQ-016 Pipeline: counter stage -> pattern stage -> output register; rgb, h_sync, v_sync, video_on and frame_start SHALL be mutually aligned, with a fixed latency of 2 pix_en ticks from the counter state.
REQ-017 mode and color SHALL be sampled only when the counters are at (0,0) with pix_en=1; changes mid-frame SHALL take effect from the next frame.
REQ-018 Mode 0: rgb = sampled color.
REQ-019 Mode 1: bar index i = x_eff*8/H_ACTIVE (0..7); each channel is all-ones if its bit of i is set (R=i[2], G=i[1], B=i[0]), else 0.
REQ-020 Mode 2: rgb = color when x_eff[5]^y[5]=0, else 0 (32x32 squares).
REQ-021 Mode 3: R = x_eff[CW+2:3], G = y[CW+2:3], B = (x_eff^y)[CW+2:3], truncated to CW bits.
REQ-022 rgb SHALL be 0 whenever the presented pixel is outside the active region.
REQ-023 With pix_en=0, all registered outputs SHALL hold their values; frame_start SHALL be high for exactly one clk.
REQ-024 x_eff = x when VGA_PATTERN_SCROLL_EN is undefined (see REQ-028).

Reset
REQ-025 On reset: h_cnt=v_cnt=0, pipeline cleared, rgb=0, video_on=0, frame_start=0, h_sync=v_sync=~SYNC_POL, sampled mode=0, sampled color=0, scroll offset=0.
REQ-026 Reset asserted mid-frame SHALL force the REQ-025 values immediately, without waiting for clk; after release, scan SHALL restart at (0,0).

Configuration
REQ-027 Macro VGA_PATTERN_SCROLL_EN SHALL select horizontal scrolling.
REQ-028 When it is defined: x_eff = (x+offset) mod H_ACTIVE for modes 1-3; offset SHALL increment by 1 at each frame start and wrap from H_ACTIVE-1 to 0. When it is undefined: no offset register, and x_eff = x.

Verification
REQ-029 Defaults, pix_en=1, release reset -> first h_sync falling edge 658 clks after release, h period 800 clks; v_sync low for 1600 clks every 420000 clks.
REQ-030 mode=0, color=12'hF80 -> rgb=12'hF80 for the 640 active clks of each line, and 0 in blanking.
REQ-031 mode=1 -> x=0..79 rgb=12'h000, x=80..159 rgb=12'h00F, x=160..239 rgb=12'h0F0, ..., x=560..639 rgb=12'hFFF.
REQ-032 mode changed 0->2 mid-frame -> no change until the next frame_start; then pixel (0,0)=color and pixel (32,0)=0.
REQ-033 pix_en toggling every other clk -> h period 1600 clks, outputs stable on non-enable clks; reset mid-line -> outputs go to reset values asynchronously.
REQ-034 With VGA_PATTERN_SCROLL_EN defined, mode=1 -> second frame pixel x=79 reads 12'h00F; after 640 frames the pattern matches frame 1.
